moore_seq_detector: RTL and testbench

Parametrised Moore-type serial pattern detector for the FSM library. It consumes one qualified input bit per clock, MSB of the pattern first, and tracks the longest matched prefix. It asserts a registered `out` while sitting in the full-match state. It adds a configurable pattern value and width, overlapping and non-overlapping match modes, an input-valid qualifier, a synchronous clear, and a saturating match counter for use by upstream protocol and line-code checkers.

---
 rtl/fsm_pkg.sv | 123 ++++++++++++
 rtl/moore_seq_next.sv | 47 ++++
 rtl/moore_seq_detector.sv | 107 ++++++++++
 tb/tb_moore_seq_detector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// -----------------------------------------------------------------------------
// fsm_pkg
// Shared elaboration-time helpers for the FSM library.
//   clog2    : ceiling log2, used to size state registers.
//   kmp_next : next matched-prefix length of a serial pattern matcher
//              (KMP automaton), with optional overlap after a full match.
// Patterns are passed LSB-aligned in a 16-bit vector; bit pat_w-1 is the
// first bit of the pattern to be matched.
// -----------------------------------------------------------------------------
package fsm_pkg;

  localparam int MAX_PAT_W = 16;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 30; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Bit idx of the pattern vector; shifting avoids a variable-width bit select.
  function automatic logic pat_bit(input logic [15:0] pattern, input int idx);
    logic [15:0] shifted;
    shifted = pattern >> idx;
    return shifted[0];
  endfunction

  // Length of the longest proper prefix of the full pattern that is also a
  // suffix of it: where matching resumes after a full match with overlap.
  function automatic int kmp_fail(input logic [15:0] pattern, input int pat_w);
    int   result;
    logic ok;
    result = 0;
    for (int len = 1; len < MAX_PAT_W; len++) begin
      if (len < pat_w) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_PAT_W; j++) begin
          if (j < len) begin
            if (pat_bit(pattern, pat_w - 1 - j) != pat_bit(pattern, len - 1 - j)) begin
              ok = 1'b0;
            end else begin
              ok = ok;
            end
          end else begin
            ok = ok;
          end
        end
        if (ok) begin
          result = len;
        end else begin
          result = result;
        end
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Next state from matched length k on bit b. From the full-match state the
  // matcher first falls back (to the border with overlap, to 0 without), then
  // consumes b. The result is the longest pattern prefix that is a suffix of
  // (matched prefix followed by b), searched by increasing length.
  function automatic int kmp_next(input logic [15:0] pattern, input int pat_w,
                                  input int k, input logic b, input logic overlap);
    int   start;
    int   seq_len;
    int   idx;
    int   result;
    logic ok;
    logic sbit;
    if (k >= pat_w) begin
      if (overlap) begin
        start = kmp_fail(pattern, pat_w);
      end else begin
        start = 0;
      end
    end else begin
      start = k;
    end
    seq_len = start + 1;
    result  = 0;
    for (int len = 1; len <= MAX_PAT_W; len++) begin
      if ((len <= seq_len) && (len <= pat_w)) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_PAT_W; j++) begin
          if (j < len) begin
            idx = seq_len - len + j;
            // position 'start' of the sequence is the new bit, earlier ones are pattern bits
            if (idx == start) begin
              sbit = b;
            end else begin
              sbit = pat_bit(pattern, pat_w - 1 - idx);
            end
            if (sbit != pat_bit(pattern, pat_w - 1 - j)) begin
              ok = 1'b0;
            end else begin
              ok = ok;
            end
          end else begin
            ok = ok;
          end
        end
        if (ok) begin
          result = len;
        end else begin
          result = result;
        end
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/moore_seq_next.sv
// -----------------------------------------------------------------------------
// moore_seq_next
// Combinational next-state function of a serial pattern matcher. The whole
// transition table is computed at elaboration with fsm_pkg::kmp_next, so the
// logic is just a lookup on (state, in). Encodings above PAT_W map to 0.
// Ports:
//   state      : current matched-prefix length (0..PAT_W)
//   in         : serial data bit
//   next_state : matched-prefix length after consuming 'in'
// -----------------------------------------------------------------------------
module moore_seq_next
  import fsm_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             SW      = clog2(PAT_W + 1)
) (
  input  logic [SW-1:0] state,
  input  logic          in,
  output logic [SW-1:0] next_state
);

  localparam int          NUM_ENC = 1 << SW;
  localparam logic [15:0] PAT16   = 16'(PATTERN);

  logic [SW-1:0] next_on0_s [NUM_ENC];
  logic [SW-1:0] next_on1_s [NUM_ENC];

  for (genvar k = 0; k < NUM_ENC; k++) begin : g_enc
    localparam int N0 = (k <= PAT_W) ? kmp_next(PAT16, PAT_W, k, 1'b0, OVERLAP) : 0;
    localparam int N1 = (k <= PAT_W) ? kmp_next(PAT16, PAT_W, k, 1'b1, OVERLAP) : 0;
    assign next_on0_s[k] = SW'(N0);
    assign next_on1_s[k] = SW'(N1);
  end

  // Table lookup of the next state for the presented bit.
  always_comb begin
    next_state = '0;
    if (in) begin
      next_state = next_on1_s[state];
    end else begin
      next_state = next_on0_s[state];
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// -----------------------------------------------------------------------------
// moore_seq_detector
// Moore serial pattern detector with input qualifier, synchronous clear and a
// saturating match counter.
// Ports:
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   in_valid  : qualifies 'in'; nothing advances while low
//   in        : serial data bit, pattern MSB first
//   clear     : synchronous clear of state, counter and sticky flag (wins over in_valid)
//   out       : 1 while the matcher sits in the full-match state
//   match_cnt : number of entries into the match state, saturating
//   cnt_sat   : sticky, set when match_cnt reaches all-ones
// -----------------------------------------------------------------------------
module moore_seq_detector
  import fsm_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               SW          = clog2(PAT_W + 1);
  localparam logic [SW-1:0]    MATCH_STATE = SW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [SW-1:0]    state_r;
  logic             out_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;

  logic [SW-1:0]    kmp_next_s;
  logic [SW-1:0]    state_d_s;
  logic             out_d_s;
  logic [CNT_W-1:0] cnt_d_s;
  logic             sat_d_s;

  moore_seq_next #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .SW      (SW)
  ) u_next (
    .state      (state_r),
    .in         (in),
    .next_state (kmp_next_s)
  );

  // Next-value selection: clear first, then an accepted bit, otherwise hold.
  always_comb begin
    state_d_s = state_r;
    out_d_s   = out_r;
    cnt_d_s   = cnt_r;
    sat_d_s   = sat_r;
    if (clear) begin
      state_d_s = '0;
      out_d_s   = 1'b0;
      cnt_d_s   = '0;
      sat_d_s   = 1'b0;
    end else if (in_valid) begin
      state_d_s = kmp_next_s;
      // out is registered from the next state, so it always equals (state == PAT_W)
      out_d_s   = (kmp_next_s == MATCH_STATE);
      if ((kmp_next_s == MATCH_STATE) && (cnt_r != CNT_MAX)) begin
        cnt_d_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_d_s = cnt_r;
      end
      sat_d_s = sat_r | (cnt_d_s == CNT_MAX);
    end else begin
      state_d_s = state_r;
      out_d_s   = out_r;
      cnt_d_s   = cnt_r;
      sat_d_s   = sat_r;
    end
  end

  // Matcher state, Moore output, counter and sticky flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= '0;
      out_r   <= 1'b0;
      cnt_r   <= '0;
      sat_r   <= 1'b0;
    end else begin
      state_r <= state_d_s;
      out_r   <= out_d_s;
      cnt_r   <= cnt_d_s;
      sat_r   <= sat_d_s;
    end
  end

  assign out       = out_r;
  assign match_cnt = cnt_r;
  assign cnt_sat   = sat_r;

endmodule

// File: tb/tb_moore_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_detector
// Four detector configurations side by side:
//   0: defaults (1011, overlap)      1: 1011, no overlap
//   2: run-of-ones (11, overlap)     3: run-of-ones with a 2-bit counter
// A table of directed vectors targets one instance per cycle; expectations
// go through a scoreboard queue and are compared after the clock edge. A
// random phase checks instances 0 and 1 against a shift-register model.
// -----------------------------------------------------------------------------
module tb_moore_seq_detector;

  typedef struct {
    int         dut;
    logic       vld;
    logic       din;
    logic       clr;
    logic       exp_out;
    logic [7:0] exp_cnt;
    logic       exp_sat;
    string      tag;
  } vec_t;

  typedef struct {
    int         dut;
    logic       out;
    logic [7:0] cnt;
    logic       sat;
    string      tag;
  } exp_t;

  logic clk;
  logic reset_n;
  logic vld [4];
  logic din [4];
  logic clr [4];

  logic       out0, out1, out2, out3;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;
  logic       sat0, sat1, sat2, sat3;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state for the random phase (instances 0 and 1)
  logic [15:0] mh    [2];
  int          mfill [2];
  int          mcnt  [2];
  logic        msat  [2];
  logic        mout  [2];

  moore_seq_detector u_def (
    .clk(clk), .reset_n(reset_n), .in_valid(vld[0]), .in(din[0]), .clear(clr[0]),
    .out(out0), .match_cnt(cnt0), .cnt_sat(sat0));

  moore_seq_detector #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .reset_n(reset_n), .in_valid(vld[1]), .in(din[1]), .clear(clr[1]),
    .out(out1), .match_cnt(cnt1), .cnt_sat(sat1));

  moore_seq_detector #(.PAT_W(2), .PATTERN(2'b11)) u_run (
    .clk(clk), .reset_n(reset_n), .in_valid(vld[2]), .in(din[2]), .clear(clr[2]),
    .out(out2), .match_cnt(cnt2), .cnt_sat(sat2));

  moore_seq_detector #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(vld[3]), .in(din[3]), .clear(clr[3]),
    .out(out3), .match_cnt(cnt3), .cnt_sat(sat3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit 200000 reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic get_dut(input int d, output logic o, output logic [7:0] c, output logic s);
    case (d)
      0:       begin o = out0; c = cnt0;            s = sat0; end
      1:       begin o = out1; c = cnt1;            s = sat1; end
      2:       begin o = out2; c = cnt2;            s = sat2; end
      default: begin o = out3; c = {6'b000000, cnt3}; s = sat3; end
    endcase
  endtask

  task automatic compare_exp(input exp_t e);
    logic       o;
    logic [7:0] c;
    logic       s;
    get_dut(e.dut, o, c, s);
    check_bit({e.tag, ".out"}, o, e.out);
    check_cnt({e.tag, ".cnt"}, c, e.cnt);
    check_bit({e.tag, ".sat"}, s, e.sat);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0;
      din[i] = 1'b0;
      clr[i] = 1'b0;
    end
  endtask

  task automatic add(input int dut, input logic v, input logic d, input logic c,
                     input logic eo, input logic [7:0] ec, input logic es, input string name);
    vec_t r;
    r.dut = dut; r.vld = v; r.din = d; r.clr = c;
    r.exp_out = eo; r.exp_cnt = ec; r.exp_sat = es;
    r.tag = $sformatf("%s#%0d", name, vecs.size());
    vecs.push_back(r);
  endtask

  // Drive one vector at the falling edge, let the rising edge take it, compare.
  task automatic run_vec(input vec_t v);
    exp_t e;
    idle_inputs();
    vld[v.dut] = v.vld;
    din[v.dut] = v.din;
    clr[v.dut] = v.clr;
    e.dut = v.dut; e.out = v.exp_out; e.cnt = v.exp_cnt; e.sat = v.exp_sat; e.tag = v.tag;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    compare_exp(e);
  endtask

  task automatic model_step(input int m, input logic v, input logic d, input logic c);
    if (c) begin
      mh[m] = '0; mfill[m] = 0; mcnt[m] = 0; msat[m] = 1'b0; mout[m] = 1'b0;
    end else if (v) begin
      mh[m] = {mh[m][14:0], d};
      if (mfill[m] < 16) mfill[m]++;
      mout[m] = (mfill[m] >= 4) && (mh[m][3:0] == 4'b1011);
      if (mout[m]) begin
        if (mcnt[m] < 255) mcnt[m]++;
        if (mcnt[m] == 255) msat[m] = 1'b1;
        if (m == 1) mfill[m] = 0;  // no overlap: restart from empty
      end
    end
  endtask

  initial begin
    logic v, d, c;
    exp_t e;

    // ---------------- directed vector table ----------------
    // overlap, stream 1,0,1,1,0,1,1
    add(0,1,1,0, 0,0,0,"ovl"); add(0,1,0,0, 0,0,0,"ovl"); add(0,1,1,0, 0,0,0,"ovl");
    add(0,1,1,0, 1,1,0,"ovl"); add(0,1,0,0, 0,1,0,"ovl"); add(0,1,1,0, 0,1,0,"ovl");
    add(0,1,1,0, 1,2,0,"ovl");
    // no overlap, same stream; then 0,1,1 completes only if state after bit 7 is 1
    add(1,1,1,0, 0,0,0,"novl"); add(1,1,0,0, 0,0,0,"novl"); add(1,1,1,0, 0,0,0,"novl");
    add(1,1,1,0, 1,1,0,"novl"); add(1,1,0,0, 0,1,0,"novl"); add(1,1,1,0, 0,1,0,"novl");
    add(1,1,1,0, 0,1,0,"novl"); add(1,1,0,0, 0,1,0,"novl"); add(1,1,1,0, 0,1,0,"novl");
    add(1,1,1,0, 1,2,0,"novl");
    // run of ones 1,1,1,1,0
    add(2,1,1,0, 0,0,0,"run"); add(2,1,1,0, 1,1,0,"run"); add(2,1,1,0, 1,2,0,"run");
    add(2,1,1,0, 1,3,0,"run"); add(2,1,0,0, 0,3,0,"run");
    // gaps: clear, then 1,0,1,1 with three invalid cycles (data 0) after each bit
    add(0,0,0,1, 0,0,0,"gap_clr");
    add(0,1,1,0, 0,0,0,"gap");
    for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,"gap_idle");
    add(0,1,0,0, 0,0,0,"gap");
    for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,"gap_idle");
    add(0,1,1,0, 0,0,0,"gap");
    for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,"gap_idle");
    add(0,1,1,0, 1,1,0,"gap");
    for (int i = 0; i < 3; i++) add(0,0,0,0, 1,1,0,"gap_hold");
    // 2-bit counter saturation with eight ones, then clear together with a valid 1
    add(3,1,1,0, 0,0,0,"sat"); add(3,1,1,0, 1,1,0,"sat"); add(3,1,1,0, 1,2,0,"sat");
    for (int i = 0; i < 5; i++) add(3,1,1,0, 1,3,1,"sat");
    add(3,1,1,1, 0,0,0,"sat_clr"); add(3,1,1,0, 0,0,0,"sat_post"); add(3,1,1,0, 1,1,0,"sat_post");
    // clear beats a match-completing bit
    add(2,1,1,0, 0,3,0,"clrwin"); add(2,1,1,1, 0,0,0,"clrwin");
    add(2,1,1,0, 0,0,0,"clrwin"); add(2,1,1,0, 1,1,0,"clrwin");

    // ---------------- reset state ----------------
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      e.dut = i; e.out = 1'b0; e.cnt = 8'd0; e.sat = 1'b0;
      e.tag = $sformatf("reset%0d", i);
      compare_exp(e);
    end
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // ---------------- asynchronous reset mid-sequence ----------------
    vecs.delete();
    add(0,0,0,1, 0,0,0,"arst_pre"); add(0,1,1,0, 0,0,0,"arst_pre");
    add(0,1,0,0, 0,0,0,"arst_pre"); add(0,1,1,0, 0,0,0,"arst_pre");
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
    idle_inputs();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      e.dut = i; e.out = 1'b0; e.cnt = 8'd0; e.sat = 1'b0;
      e.tag = $sformatf("arst%0d", i);
      compare_exp(e);
    end
    @(negedge clk);
    reset_n = 1'b1;
    vecs.delete();
    add(0,1,1,0, 0,0,0,"arst_post");
    add(0,1,0,0, 0,0,0,"arst_post"); add(0,1,1,0, 0,0,0,"arst_post");
    add(0,1,1,0, 1,1,0,"arst_post");
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // ---------------- random stream vs model (instances 0 and 1) ----------------
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 1) != 0);
      c = (i == 0) || ($urandom_range(0, 39) == 0);
      idle_inputs();
      for (int m = 0; m < 2; m++) begin
        vld[m] = v; din[m] = d; clr[m] = c;
        model_step(m, v, d, c);
        e.dut = m; e.out = mout[m]; e.cnt = 8'(mcnt[m]); e.sat = msat[m];
        e.tag = $sformatf("rnd%0d.d%0d", i, m);
        sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        e = sb.pop_front();
        compare_exp(e);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
